// File: rtl/mem_access_unit.sv
// Load/store unit: aligns CPU byte/half/word accesses onto a 32-bit req/ack memory port with misalignment and ack-timeout errors.
// Latency: mem_req from the cycle after accept, response strobe the cycle after mem_ack (or after the timeout); one access in flight, no response back-pressure.
module mem_access_unit #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [1:0]  resp_err,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   // Last ACCESS cycle before timeout; an ack in that same cycle still wins.
   localparam logic [7:0] WAIT_LIMIT = 8'(ACK_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [1:0]  lane_q;
   logic [7:0]  wait_cnt;

   logic        is_half, is_word, is_store, misaligned;
   logic [3:0]  be_nxt;
   logic [31:0] wd_nxt;

   function automatic logic [31:0] extract(input logic [2:0] lop, input logic [1:0] lane,
                                           input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (lop)
         OP_LB:   extract = {{24{b[7]}}, b};
         OP_LBU:  extract = {24'd0, b};
         OP_LH:   extract = {{16{h[15]}}, h};
         OP_LHU:  extract = {16'd0, h};
         OP_LW:   extract = word;
         default: extract = 32'd0;
      endcase
   endfunction

   always_comb begin
      is_half    = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      is_word    = (op == OP_LW) || (op == OP_SW);
      is_store   = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
      misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
      be_nxt     = 4'b1111;
      wd_nxt     = 32'd0;
      case (op)
         OP_SB: begin
            be_nxt = 4'b0001 << addr[1:0];
            wd_nxt = {4{wdata[7:0]}};
         end
         OP_SH: begin
            be_nxt = addr[1] ? 4'b1100 : 4'b0011;
            wd_nxt = {2{wdata[15:0]}};
         end
         OP_SW:   wd_nxt = wdata;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = misaligned ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            if (mem_ack || (wait_cnt == WAIT_LIMIT)) state_nxt = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= 3'd0;
         lane_q    <= 2'd0;
         wait_cnt  <= 8'd0;
         resp_err  <= 2'b00;
         rdata     <= 32'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'd0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q     <= op;
                  lane_q   <= addr[1:0];
                  wait_cnt <= 8'd0;
                  if (misaligned) begin
                     resp_err <= 2'b01;
                     rdata    <= 32'd0;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_be    <= be_nxt;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_wdata <= wd_nxt;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  resp_err <= 2'b00;
                  rdata    <= extract(op_q, lane_q, mem_rdata);
               end else if (wait_cnt == WAIT_LIMIT) begin
                  mem_req  <= 1'b0;
                  resp_err <= 2'b10;
                  rdata    <= 32'd0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a short ack timeout.
module tb_mem_access_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  op = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        resp_valid;
   logic [1:0]  resp_err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .op(op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
      .resp_err(resp_err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   typedef struct { logic [1:0] err; logic [31:0] rdata; int cyc; } rexp_t;
   typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wd; int len; } mexp_t;
   rexp_t rq[$];
   mexp_t mq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain arithmetic on the access rules.
   function automatic bit ref_misaligned(input logic [2:0] o, input logic [31:0] a);
      int sz;
      sz = (o == 3'd0 || o == 3'd1 || o == 3'd5) ? 1 : (o == 3'd4 || o == 3'd7) ? 4 : 2;
      return (a % sz) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> ((a % 4) * 8)) & 32'hFF;
      h = (w >> (((a % 4) / 2) * 16)) & 32'hFFFF;
      case (o)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd1:    return b;
         3'd2:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd3:    return h;
         3'd4:    return w;
         default: return 32'd0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_mem(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                           input int len);
      mexp_t m;
      m.we   = (o >= 3'd5);
      m.addr = a - (a % 4);
      m.len  = len;
      m.be   = 4'hF;
      m.wd   = 32'd0;
      if (o == 3'd5) begin
         m.be = 4'(1 << (a % 4));
         m.wd = (wd & 32'hFF) * 32'h0101_0101;
      end else if (o == 3'd6) begin
         m.be = ((a % 4) >= 2) ? 4'hC : 4'h3;
         m.wd = (wd & 32'hFFFF) * 32'h0001_0001;
      end else if (o == 3'd7) begin
         m.wd = wd;
      end
      mq.push_back(m);
   endtask

   // k = cycle of ACCESS (1-based) in which mem_ack is given; k > TO means never.
   task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input int k, input logic [31:0] rd);
      int    acc;
      bit    mis;
      rexp_t r;
      check("req_ready_idle", 64'(req_ready), 64'd1);
      acc = cyc + 1;
      mis = ref_misaligned(o, a);
      if (mis) begin
         r = '{2'b01, 32'd0, acc};
      end else begin
         push_mem(o, a, wd, (k <= TO) ? k : TO);
         if (k <= TO) r = '{2'b00, ref_load(o, a, rd), acc + k};
         else         r = '{2'b10, 32'd0, acc + TO};
      end
      rq.push_back(r);
      req_valid = 1'b1;
      op = o;
      addr = a;
      wdata = wd;
      tick();
      req_valid = 1'b0;
      op = 3'($urandom);
      addr = $urandom;
      wdata = $urandom;
      if (!mis) begin
         if (k <= TO) begin
            repeat (k - 1) tick();
            mem_ack = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack = 1'b0;
         end else begin
            repeat (TO) tick();
         end
      end
      // Response cycle: a stray ack here must not disturb the result.
      mem_ack = 1'($urandom);
      mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
      check("hold_rdata", 64'(rdata), 64'(r.rdata));
      check("hold_err", 64'(resp_err), 64'(r.err));
   endtask

   task automatic idle_gap(input int n);
      repeat (n) begin
         mem_ack = 1'($urandom);
         mem_rdata = $urandom;
         tick();
         mem_ack = 1'b0;
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   bit    in_acc = 1'b0;
   int    run = 0;
   mexp_t cur;
   always @(negedge clk) begin
      if (mon_en) begin
         if (resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
               check("resp_unexpected", 64'd1, 64'd0);
            end else begin
               rexp_t e;
               e = rq.pop_front();
               check("resp_err", 64'(resp_err), 64'(e.err));
               check("resp_rdata", 64'(rdata), 64'(e.rdata));
               check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (mem_req === 1'b1) begin
            if (!in_acc) begin
               in_acc = 1'b1;
               run = 0;
               if (mq.size() == 0) begin
                  check("mem_req_unexpected", 64'd1, 64'd0);
                  cur = '{1'b0, 4'd0, 32'd0, 32'd0, 0};
               end else begin
                  cur = mq.pop_front();
               end
            end
            run++;
            check("mem_ctl", {59'd0, mem_we, mem_be}, {59'd0, cur.we, cur.be});
            check("mem_addr_wdata", {mem_addr, mem_wdata}, {cur.addr, cur.wd});
         end else if (in_acc) begin
            in_acc = 1'b0;
            check("mem_req_len", 64'(run), 64'(cur.len));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  o;
      logic [31:0] a;
      rst = 1'b1;
      tick();
      tick();
      check("rst_ready_valid", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
      check("rst_mem_ctl", {58'd0, mem_req, mem_we, mem_be}, 64'd0);
      check("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
      check("rst_resp", {30'd0, resp_err, rdata}, 64'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      do_req(3'd0, 32'h0000_1003, 32'd0, 1, 32'h80FF_1234);  // LB
      do_req(3'd3, 32'h0000_2002, 32'd0, 2, 32'h9ABC_0000);  // LHU
      do_req(3'd2, 32'h0000_2002, 32'd0, 3, 32'h9ABC_0000);  // LH
      do_req(3'd5, 32'h0000_0011, 32'h1234_56A5, 1, $urandom);  // SB
      do_req(3'd6, 32'h0000_0012, 32'h1234_56A5, 2, $urandom);  // SH
      do_req(3'd4, 32'h0000_0005, 32'd0, 1, $urandom);  // misaligned LW
      do_req(3'd6, 32'h0000_0003, 32'd0, 1, $urandom);  // misaligned SH
      do_req(3'd4, 32'h0000_0040, 32'd0, TO + 1, $urandom);  // timeout
      idle_gap(2);
      do_req(3'd4, 32'h0000_0044, 32'd0, TO, 32'hDEAD_BEEF);  // ack on the last allowed cycle

      // Reset in the middle of an access, then a late ack.
      check("req_ready_idle", 64'(req_ready), 64'd1);
      push_mem(3'd4, 32'h0000_0100, 32'd0, 2);
      req_valid = 1'b1;
      op = 3'd4;
      addr = 32'h0000_0100;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready_req", {62'd0, req_ready, mem_req}, {62'd0, 1'b1, 1'b0});
      check("abort_no_resp", 64'(resp_valid), 64'd0);
      mem_ack = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0;
      check("late_ack_ignored", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
      do_req(3'd1, 32'h0000_0201, 32'd0, 1, 32'h0000_F100);

      for (int n = 0; n < 300; n++) begin
         o = 3'($urandom);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (o == 3'd2 || o == 3'd3 || o == 3'd6) a[0] = 1'b0;
            if (o == 3'd4 || o == 3'd7) a[1:0] = 2'b00;
         end
         do_req(o, a, $urandom, $urandom_range(1, TO + 1), $urandom);
         idle_gap($urandom_range(0, 2));
      end

      repeat (3) tick();
      check("resp_queue_empty", 64'(rq.size()), 64'd0);
      check("mem_queue_empty", 64'(mq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
